// File: rtl/spi_slave_packet_tx.sv
// spi_slave_packet_tx
// SPI slave transmitter that streams a fixed-format sensor packet on MISO.
// SCK and CS are oversampled in the clk domain; they are never used as clocks.
//
// Packet: HEADER, words[0..NUM_WORDS-1] (MSB byte first), flags, seq,
// and an optional 8-bit checksum. All bits are sent MSB first.
//
// Build option:
//   SPI_SLAVE_CHECKSUM_EN  append the mod-256 checksum byte
//                          (packet = 2*NUM_WORDS+4 bytes, else +3)
//
// Ports:
//   clk          system clock, at least 8x f_sck
//   rst_n        asynchronous active-low reset
//   cs_n         MCU chip select (async, active low)
//   sck          MCU SPI clock (async)
//   sdo          MISO data (shift register MSB)
//   sdo_oe       MISO output enable, = !cs_n
//   words        packed 16-bit words, word 0 in the LSBs
//   flags        status flags byte
//   busy         frame in progress (LOAD or SHIFT)
//   frame_done   one-cycle pulse at the end of a complete frame
//   frame_abort  one-cycle pulse when CS rises before the last bit
//   seq          sequence number of the next frame

module spi_slave_packet_tx #(
    parameter int         NUM_WORDS = 7,
    parameter logic [7:0] HEADER    = 8'hAA,
    parameter bit         CPOL      = 1'b0,
    parameter bit         CPHA      = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cs_n,
    input  logic                   sck,
    output logic                   sdo,
    output logic                   sdo_oe,
    input  logic [16*NUM_WORDS-1:0] words,
    input  logic [7:0]             flags,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_abort,
    output logic [7:0]             seq
);

`ifdef SPI_SLAVE_CHECKSUM_EN
    localparam int PB = 2 * NUM_WORDS + 4;
`else
    localparam int PB = 2 * NUM_WORDS + 3;
`endif

    localparam logic [6:0] PB_C    = 7'(PB);
    localparam logic [6:0] LAST_C  = 7'(PB - 1);
    localparam logic [6:0] W2_C    = 7'(2 * NUM_WORDS);
    localparam logic [6:0] FLAGS_C = 7'(2 * NUM_WORDS + 1);
    localparam logic [6:0] SEQ_C   = 7'(2 * NUM_WORDS + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_e;

    // ------------------------------------------------------------------
    // Pin synchronizers: [0],[1] synchronize, [2] is the edge reference
    // ------------------------------------------------------------------
    logic [2:0] cs_sync_q;
    logic [2:0] sck_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q  <= 3'b111;
            sck_sync_q <= {3{CPOL}};
        end else begin
            cs_sync_q  <= {cs_sync_q[1:0], cs_n};
            sck_sync_q <= {sck_sync_q[1:0], sck};
        end
    end

    logic cs_fall;
    logic cs_rise;
    logic sck_rise;
    logic sck_fall;
    logic lead_edge;
    logic trail_edge;
    logic launch;

    assign cs_fall    = cs_sync_q[2] & ~cs_sync_q[1];
    assign cs_rise    = ~cs_sync_q[2] & cs_sync_q[1];
    assign sck_rise   = ~sck_sync_q[2] & sck_sync_q[1];
    assign sck_fall   = sck_sync_q[2] & ~sck_sync_q[1];
    assign lead_edge  = CPOL ? sck_fall : sck_rise;
    assign trail_edge = CPOL ? sck_rise : sck_fall;
    // Slave launches on the edge the MCU does not sample on
    assign launch     = CPHA ? lead_edge : trail_edge;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                   state_q, state_d;
    logic [7:0]               sr_q, sr_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [6:0]               byte_cnt_q, byte_cnt_d;
    logic                     first_q, first_d;
    logic [16*NUM_WORDS-1:0]  snap_w_q, snap_w_d;
    logic [7:0]               snap_f_q, snap_f_d;
    logic [7:0]               seq_q, seq_d;
    logic                     abort_q, abort_d;
    logic                     fall_pend_q, fall_pend_d;
`ifdef SPI_SLAVE_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
`endif

    // Last packet bit is on sdo once bit 0 of the last byte is presented
    logic complete;
    assign complete = (byte_cnt_q == PB_C) ||
                      ((byte_cnt_q == LAST_C) && (bit_cnt_q == 3'd7));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cs_fall || fall_pend_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = cs_rise ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                if (cs_rise) state_d = complete ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state_q == S_LOAD) || (state_q == S_SHIFT);
        frame_done  = (state_q == S_DONE);
        frame_abort = abort_q;
        seq         = seq_q;
        sdo         = sr_q[7];
        sdo_oe      = ~cs_n;
    end

    // ------------------------------------------------------------------
    // Next packet byte, indexed by the byte that follows the current one
    // ------------------------------------------------------------------
    logic [6:0] nidx;
    logic [7:0] nb;

    assign nidx = byte_cnt_q + 7'd1;

    // The word snapshot shifts right by one word after each LSB byte,
    // so the word being sent is always in snap_w_q[15:0].
    always_comb begin
        nb = 8'h00;
        if (nidx <= W2_C) begin
            nb = nidx[0] ? snap_w_q[15:8] : snap_w_q[7:0];
        end else if (nidx == FLAGS_C) begin
            nb = snap_f_q;
        end else if (nidx == SEQ_C) begin
            nb = seq_q;
`ifdef SPI_SLAVE_CHECKSUM_EN
        end else if (nidx == LAST_C) begin
            nb = csum_q;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        first_d    = first_q;
        snap_w_d   = snap_w_q;
        snap_f_d   = snap_f_q;
`ifdef SPI_SLAVE_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        seq_d       = (state_q == S_DONE) ? seq_q + 8'd1 : seq_q;
        fall_pend_d = (state_q == S_DONE) && cs_fall;
        abort_d     = cs_rise &&
                      ((state_q == S_LOAD) ||
                       ((state_q == S_SHIFT) && !complete));

        unique case (state_q)
            S_IDLE: begin
                sr_d       = HEADER;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 7'd0;
                first_d    = CPHA;
            end
            S_LOAD: begin
                sr_d       = HEADER;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 7'd0;
                first_d    = CPHA;
                snap_w_d   = words;
                snap_f_d   = flags;
`ifdef SPI_SLAVE_CHECKSUM_EN
                csum_d     = 8'h00;
`endif
            end
            S_SHIFT: begin
                // CS rise has priority over a coincident SCK edge
                if (launch && !cs_rise) begin
                    if (first_q) begin
                        // CPHA=1: first launch only presents bit 7
                        first_d = 1'b0;
                    end else if (bit_cnt_q == 3'd7) begin
                        sr_d      = nb;
                        bit_cnt_d = 3'd0;
                        if (byte_cnt_q != PB_C) byte_cnt_d = nidx;
                        if ((nidx <= W2_C) && !nidx[0]) begin
                            snap_w_d = snap_w_q >> 16;
                        end
`ifdef SPI_SLAVE_CHECKSUM_EN
                        // HEADER is folded in with the first loaded byte
                        if (nidx <= SEQ_C) begin
                            csum_d = csum_q + nb +
                                     ((byte_cnt_q == 7'd0) ? HEADER : 8'h00);
                        end
`endif
                    end else begin
                        sr_d      = {sr_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= HEADER;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 7'd0;
            first_q     <= CPHA;
            snap_w_q    <= '0;
            snap_f_q    <= 8'h00;
            seq_q       <= 8'h00;
            abort_q     <= 1'b0;
            fall_pend_q <= 1'b0;
`ifdef SPI_SLAVE_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            first_q     <= first_d;
            snap_w_q    <= snap_w_d;
            snap_f_q    <= snap_f_d;
            seq_q       <= seq_d;
            abort_q     <= abort_d;
            fall_pend_q <= fall_pend_d;
`ifdef SPI_SLAVE_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_slave_packet_tx.sv
// tb_spi_slave_packet_tx
// Directed bench: mode 0 and mode 3 instances, abort, overrun, snapshot, reset.

module tb_spi_slave_packet_tx;

    localparam int NW = 7;
`ifdef SPI_SLAVE_CHECKSUM_EN
    localparam int PB = 2 * NW + 4;
    localparam bit CK = 1'b1;
`else
    localparam int PB = 2 * NW + 3;
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            cs0, sck0, cs3, sck3;
    logic [16*NW-1:0] words;
    logic [7:0]      flags;

    logic       sdo0, oe0, busy0, done0, abort0;
    logic [7:0] seq0;
    logic       sdo3, oe3, busy3, done3, abort3;
    logic [7:0] seq3;

    spi_slave_packet_tx #(
        .NUM_WORDS(NW), .HEADER(8'hAA), .CPOL(1'b0), .CPHA(1'b0)
    ) u_m0 (
        .clk(clk), .rst_n(rst_n), .cs_n(cs0), .sck(sck0),
        .sdo(sdo0), .sdo_oe(oe0), .words(words), .flags(flags),
        .busy(busy0), .frame_done(done0), .frame_abort(abort0), .seq(seq0)
    );

    spi_slave_packet_tx #(
        .NUM_WORDS(NW), .HEADER(8'hAA), .CPOL(1'b1), .CPHA(1'b1)
    ) u_m3 (
        .clk(clk), .rst_n(rst_n), .cs_n(cs3), .sck(sck3),
        .sdo(sdo3), .sdo_oe(oe3), .words(words), .flags(flags),
        .busy(busy3), .frame_done(done3), .frame_abort(abort3), .seq(seq3)
    );

    int total = 0;
    int bad = 0;
    int dn0 = 0, ab0 = 0, dn3 = 0, ab3 = 0;
    logic [7:0] rx [0:31];

    always @(negedge clk) begin
        if (done0)  dn0++;
        if (abort0) ab0++;
        if (done3)  dn3++;
        if (abort3) ab3++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] raw_byte(int i, logic [16*NW-1:0] w,
                                            logic [7:0] f, logic [7:0] s);
        logic [16*NW-1:0] t;
        if (i == 0) return 8'hAA;
        if (i <= 2 * NW) begin
            t = w >> (16 * ((i - 1) / 2));
            return (i % 2 == 1) ? t[15:8] : t[7:0];
        end
        if (i == 2 * NW + 1) return f;
        if (i == 2 * NW + 2) return s;
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_byte(int i, logic [16*NW-1:0] w,
                                            logic [7:0] f, logic [7:0] s);
        logic [7:0] sum;
        sum = 8'h00;
        if (CK && i == 2 * NW + 3) begin
            for (int j = 0; j <= 2 * NW + 2; j++) sum = sum + raw_byte(j, w, f, s);
            return sum;
        end
        return raw_byte(i, w, f, s);
    endfunction

    task automatic half();
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_byte(input bit m3, input int nbits, output logic [7:0] b);
        b = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            if (!m3) begin
                b = {b[6:0], sdo0};
                sck0 = 1'b1;
                half();
                sck0 = 1'b0;
                half();
            end else begin
                sck3 = 1'b0;
                half();
                b = {b[6:0], sdo3};
                sck3 = 1'b1;
                half();
            end
        end
    endtask

    task automatic run_frame(input bit m3, input int nb, input int chg_at,
                             input int rst_at);
        bit killed;
        killed = 1'b0;
        if (m3) cs3 = 1'b0;
        else cs0 = 1'b0;
        repeat (10) @(negedge clk);
        if (!m3) begin
            chk("oe_low_cs", oe0, 1);
            chk("busy_in_frame", busy0, 1);
        end
        for (int i = 0; i < nb; i++) begin
            if (i == chg_at) words[15:0] = 16'h2222;
            if (i == rst_at) begin
                spi_byte(m3, 4, rx[i]);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                chk("rst_busy", busy0, 0);
                chk("rst_seq", seq0, 0);
                chk("rst_sdo", sdo0, 1);
                chk("rst_abort", abort0, 0);
                chk("rst_done", done0, 0);
                sck0 = 1'b0;
                cs0 = 1'b1;
                repeat (4) @(negedge clk);
                rst_n = 1'b1;
                repeat (8) @(negedge clk);
                killed = 1'b1;
                break;
            end
            spi_byte(m3, 8, rx[i]);
        end
        if (!killed) begin
            repeat (8) @(negedge clk);
            if (m3) cs3 = 1'b1;
            else cs0 = 1'b1;
            repeat (12) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cs0 = 1'b1; sck0 = 1'b0;
        cs3 = 1'b1; sck3 = 1'b1;
        words = '0;
        flags = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // reset state
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_abort", abort0, 0);
        chk("reset_seq", seq0, 0);
        chk("reset_sdo", sdo0, 1);
        chk("reset_oe", oe0, 0);
        chk("reset_seq3", seq3, 0);

        // mode 0, all-zero words, flags 03
        flags = 8'h03;
        run_frame(1'b0, PB, -1, -1);
        chk("m0_hdr", rx[0], 8'hAA);
        chk("m0_flags", rx[2*NW+1], 8'h03);
        chk("m0_seqb", rx[2*NW+2], 8'h00);
`ifdef SPI_SLAVE_CHECKSUM_EN
        chk("m0_csum", rx[2*NW+3], 8'hAD);
`endif
        for (int i = 0; i < PB; i++)
            chk($sformatf("m0_b%0d", i), rx[i], exp_byte(i, '0, 8'h03, 8'h00));
        chk("m0_done_cnt", dn0, 1);
        chk("m0_abort_cnt", ab0, 0);
        chk("m0_seq", seq0, 1);
        chk("m0_busy_end", busy0, 0);

        // mode 3
        words = '0;
        words[15:0] = 16'h1234;
        flags = 8'h00;
        run_frame(1'b1, PB, -1, -1);
        chk("m3_hdr", rx[0], 8'hAA);
        chk("m3_b1", rx[1], 8'h12);
        chk("m3_b2", rx[2], 8'h34);
`ifdef SPI_SLAVE_CHECKSUM_EN
        chk("m3_csum", rx[2*NW+3], 8'hF0);
`endif
        for (int i = 0; i < PB; i++)
            chk($sformatf("m3_b%0d", i), rx[i], exp_byte(i, words, 8'h00, 8'h00));
        chk("m3_done_cnt", dn3, 1);
        chk("m3_abort_cnt", ab3, 0);
        chk("m3_seq", seq3, 1);

        // abort after 5 bytes, then a full frame
        words = '0;
        flags = 8'h03;
        run_frame(1'b0, 5, -1, -1);
        chk("ab_abort_cnt", ab0, 1);
        chk("ab_done_cnt", dn0, 1);
        chk("ab_seq", seq0, 1);
        run_frame(1'b0, PB, -1, -1);
        chk("ab_next_hdr", rx[0], 8'hAA);
        chk("ab_next_seqb", rx[2*NW+2], 8'h01);
        for (int i = 0; i < PB; i++)
            chk($sformatf("ab_b%0d", i), rx[i], exp_byte(i, '0, 8'h03, 8'h01));
        chk("ab_next_done", dn0, 2);
        chk("ab_next_seq", seq0, 2);

        // overrun: two extra bytes
        run_frame(1'b0, PB + 2, -1, -1);
        chk("ov_x0", rx[PB], 8'h00);
        chk("ov_x1", rx[PB+1], 8'h00);
        chk("ov_seqb", rx[2*NW+2], 8'h02);
        chk("ov_done_cnt", dn0, 3);
        chk("ov_abort_cnt", ab0, 1);
        chk("ov_seq", seq0, 3);

        // snapshot: words[0] changes during byte 3
        words = '0;
        words[15:0] = 16'h1111;
        run_frame(1'b0, PB, 3, -1);
        chk("sn_n_b1", rx[1], 8'h11);
        chk("sn_n_b2", rx[2], 8'h11);
        chk("sn_n_last", rx[PB-1], exp_byte(PB - 1, 112'h1111, 8'h03, 8'h03));
        run_frame(1'b0, PB, -1, -1);
        chk("sn_n1_b1", rx[1], 8'h22);
        chk("sn_n1_b2", rx[2], 8'h22);
        chk("sn_n1_last", rx[PB-1], exp_byte(PB - 1, 112'h2222, 8'h03, 8'h04));
        chk("sn_seq", seq0, 5);

        // reset in the middle of byte 6
        run_frame(1'b0, PB, -1, 6);
        chk("rs_seq", seq0, 0);
        chk("rs_busy", busy0, 0);
        chk("rs_sdo", sdo0, 1);
        run_frame(1'b0, PB, -1, -1);
        for (int i = 0; i < PB; i++)
            chk($sformatf("rs_b%0d", i), rx[i], exp_byte(i, words, 8'h03, 8'h00));
        chk("rs_done_cnt", dn0, 6);
        chk("rs_abort_cnt", ab0, 1);
        chk("rs_seq_after", seq0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
